// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 storage, two combinational read ports and one write port.
// Write lands one clock after wb_valid, reads take zero cycles, and the block never stalls.
module wb_regfile #(
  parameter logic BYPASS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [1:0]  s_data_write,
  input  logic [4:0]  num_write,
  input  logic [31:0] pc_4,
  input  logic [31:0] alu,
  input  logic [31:0] mem,
  input  logic [4:0]  rs_num,
  input  logic [4:0]  rt_num,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  output logic        wb_valid
);

  logic [31:0] regs [32];

  always_comb begin
    wb_data = alu;
    case (s_data_write)
      2'b01:   wb_data = mem;
      2'b10:   wb_data = pc_4;
      default: wb_data = alu;
    endcase
  end

  // Reset masks the write strobe, which also suppresses forwarding while reset is held.
  assign wb_valid = reg_write && (num_write != 5'd0) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0000_0000;
      end
    end else if (wb_valid) begin
      regs[num_write] <= wb_data;
    end
  end

  always_comb begin
    rs_data = regs[rs_num];
    if (rs_num == 5'd0) begin
      rs_data = 32'h0000_0000;
    end else if (BYPASS && wb_valid && (rs_num == num_write)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs[rt_num];
    if (rt_num == 5'd0) begin
      rt_data = 32'h0000_0000;
    end else if (BYPASS && wb_valid && (rt_num == num_write)) begin
      rt_data = wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a forwarding and a non-forwarding instance share the same stimulus.
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [1:0]  s_data_write;
  logic [4:0]  num_write;
  logic [31:0] pc_4, alu, mem;
  logic [4:0]  rs_num, rt_num;
  logic [31:0] rs_b, rt_b, wb_b;
  logic        wv_b;
  logic [31:0] rs_n, rt_n, wb_n;
  logic        wv_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  wb_regfile #(.BYPASS(1'b1)) u_byp (
    .clock(clock), .reset(reset), .reg_write(reg_write), .s_data_write(s_data_write),
    .num_write(num_write), .pc_4(pc_4), .alu(alu), .mem(mem),
    .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_b), .rt_data(rt_b),
    .wb_data(wb_b), .wb_valid(wv_b)
  );

  wb_regfile #(.BYPASS(1'b0)) u_nobyp (
    .clock(clock), .reset(reset), .reg_write(reg_write), .s_data_write(s_data_write),
    .num_write(num_write), .pc_4(pc_4), .alu(alu), .mem(mem),
    .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_n), .rt_data(rt_n),
    .wb_data(wb_n), .wb_valid(wv_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] sel, input logic [4:0] idx,
                          input logic [31:0] a, input logic [31:0] m, input logic [31:0] p);
    reg_write    = 1'b1;
    s_data_write = sel;
    num_write    = idx;
    alu          = a;
    mem          = m;
    pc_4         = p;
  endtask

  task automatic read_both(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    rs_num = idx;
    rt_num = idx;
    #1;
    check({tag, " rs byp"},   rs_b, exp);
    check({tag, " rt byp"},   rt_b, exp);
    check({tag, " rs nobyp"}, rs_n, exp);
    check({tag, " rt nobyp"}, rt_n, exp);
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; s_data_write = 2'b00; num_write = 5'd0;
    pc_4 = '0; alu = '0; mem = '0; rs_num = 5'd0; rt_num = 5'd0;
    tick();
    tick();
    reset = 1'b0;

    // every index reads zero after reset
    for (int i = 0; i < 32; i++) begin
      rs_num = 5'(i);
      rt_num = 5'(31 - i);
      #1;
      check($sformatf("rst rs%0d", i), rs_b, 32'h0);
      check($sformatf("rst rt%0d", 31 - i), rt_n, 32'h0);
    end

    // three write-back sources
    rs_num = 5'd0; rt_num = 5'd0;
    drive_wr(2'b00, 5'd5, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222);
    #1;
    check("wb_data sel00", wb_b, 32'hDEAD_BEEF);
    check("wb_valid r5", {31'b0, wv_b}, 32'h1);
    tick();
    drive_wr(2'b01, 5'd6, 32'h3333_3333, 32'h1234_5678, 32'h4444_4444);
    #1;
    check("wb_data sel01", wb_b, 32'h1234_5678);
    tick();
    drive_wr(2'b10, 5'd31, 32'h5555_0000, 32'h6666_0000, 32'h0040_0008);
    #1;
    check("wb_data sel10", wb_n, 32'h0040_0008);
    tick();
    drive_wr(2'b11, 5'd0, 32'h7777_7777, 32'h8888_8888, 32'h9999_9999);
    #1;
    check("wb_data sel11", wb_b, 32'h7777_7777);
    check("wb_valid r0 sel11", {31'b0, wv_b}, 32'h0);
    reg_write = 1'b0;
    read_both("r5", 5'd5, 32'hDEAD_BEEF);
    read_both("r6", 5'd6, 32'h1234_5678);
    read_both("r31", 5'd31, 32'h0040_0008);

    // writes to r0 are dropped
    drive_wr(2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    #1;
    check("wb_valid r0", {31'b0, wv_b}, 32'h0);
    tick();
    reg_write = 1'b0;
    read_both("r0", 5'd0, 32'h0);

    // same-cycle forwarding vs stored value
    drive_wr(2'b00, 5'd7, 32'hA5A5_A5A5, 32'h0, 32'h0);
    rs_num = 5'd7; rt_num = 5'd7;
    #1;
    check("fwd rs byp",   rs_b, 32'hA5A5_A5A5);
    check("fwd rt byp",   rt_b, 32'hA5A5_A5A5);
    check("fwd rs nobyp", rs_n, 32'h0);
    check("fwd rt nobyp", rt_n, 32'h0);
    tick();
    reg_write = 1'b0;
    read_both("r7", 5'd7, 32'hA5A5_A5A5);

    // reset beats a simultaneous write and blocks forwarding
    reset = 1'b1;
    drive_wr(2'b00, 5'd3, 32'h0000_0011, 32'h0, 32'h0);
    rs_num = 5'd3; rt_num = 5'd5;
    #1;
    check("rst wb_valid", {31'b0, wv_b}, 32'h0);
    check("rst wb_data", wb_b, 32'h0000_0011);
    check("rst no fwd rs", rs_b, 32'h0);
    check("rst stored rt", rt_b, 32'hDEAD_BEEF);
    tick();
    reset = 1'b0;
    drive_wr(2'b00, 5'd3, 32'h0000_0022, 32'h0, 32'h0);
    rs_num = 5'd3; rt_num = 5'd3;
    #1;
    check("post rst fwd", rs_b, 32'h0000_0022);
    check("post rst stored", rs_n, 32'h0);
    tick();
    reg_write = 1'b0;
    read_both("r3", 5'd3, 32'h0000_0022);
    read_both("r5 cleared", 5'd5, 32'h0);
    read_both("r7 cleared", 5'd7, 32'h0);

    // reg_write low leaves storage alone
    reg_write = 1'b0; s_data_write = 2'b00; num_write = 5'd9; alu = 32'h5555_5555;
    rs_num = 5'd9; rt_num = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("idle wb_valid %0d", c), {31'b0, wv_b}, 32'h0);
      tick();
      check($sformatf("idle r9 byp %0d", c), rs_b, 32'h0);
      check($sformatf("idle r9 nobyp %0d", c), rt_n, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one parameter: BYPASS, default 1, meaning 1 enables write-through forwarding on reads and 0 disables it.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clock.
REQ-004 The block SHALL have port reg_write, input, 1 bit: write enable from the MEM/WB register.
REQ-005 The block SHALL have port s_data_write, input, 2 bits: write-back source select.
REQ-006 The block SHALL have port num_write, input, 5 bits: destination register index.
REQ-007 The block SHALL have port pc_4, input, 32 bits: return address for link instructions.
REQ-008 The block SHALL have port alu, input, 32 bits: ALU result.
REQ-009 The block SHALL have port mem, input, 32 bits: data-memory load result.
REQ-010 The block SHALL have port rs_num, input, 5 bits: read port A index.
REQ-011 The block SHALL have port rt_num, input, 5 bits: read port B index.
REQ-012 The block SHALL have port rs_data, output, 32 bits: read port A data.
REQ-013 The block SHALL have port rt_data, output, 32 bits: read port B data.
REQ-014 The block SHALL have port wb_data, output, 32 bits: selected write-back value, for EX-stage forwarding.
REQ-015 The block SHALL have port wb_valid, output, 1 bit: asserted when a real write to a nonzero register occurs this cycle.

Function
REQ-016 Storage SHALL be 32 registers of 32 bits, indices 0-31.
REQ-017 wb_data SHALL be combinational: s_data_write 00 selects alu, 01 selects mem, 10 selects pc_4, and 11 selects alu.
REQ-018 wb_valid SHALL equal reg_write AND (num_write != 0) AND NOT reset, combinationally.
REQ-019 On a rising clock with reset=0 and wb_valid=1, register[num_write] SHALL load wb_data; write latency is 1 cycle.
REQ-020 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and SHALL NOT change any state.
REQ-021 Reads SHALL be combinational (0-cycle) on rs_num and rt_num.
REQ-022 With BYPASS=1, a read whose index equals num_write while wb_valid=1 SHALL return wb_data (same-cycle write-through).
REQ-023 With BYPASS=0, such a read SHALL return the pre-write stored value; the new value is visible the next cycle.
REQ-024 Both read ports reading the same index simultaneously SHALL return identical data.
REQ-025 reg_write=0 SHALL leave all storage unchanged regardless of s_data_write and num_write.
REQ-026 X or don't-care on alu, mem, or pc_4 SHALL NOT affect storage when wb_valid=0.

Reset
REQ-027 When reset=1 at a rising clock, all 32 registers SHALL become 32'h0000_0000.
REQ-028 Reset SHALL take priority over a simultaneous write; the write is lost.
REQ-029 While reset=1, wb_valid SHALL be 0 and no bypass SHALL occur, so rs_data and rt_data reflect stored values only.
REQ-030 After reset deasserts, the first write SHALL take effect on the first rising clock with reset=0.
REQ-031 wb_data SHALL remain a pure function of its inputs during reset.

Verification
REQ-032 Reset, then read all indices -> every rs_data and rt_data equals 0.
REQ-033 Write alu=32'hDEAD_BEEF to r5 (s_data_write=00), then read r5 on the next cycle -> rs_data=32'hDEAD_BEEF; select 01 with mem=32'h1234_5678 to r6 -> r6=32'h1234_5678; select 10 with pc_4=32'h0040_0008 to r31 -> r31=32'h0040_0008.
REQ-034 Write alu=32'hFFFF_FFFF to r0 -> wb_valid=0 and r0 reads 0 on the following cycle.
REQ-035 BYPASS=1: write r7=32'hA5A5_A5A5 with rs_num=rt_num=7 in the same cycle -> both ports show 32'hA5A5_A5A5 before the edge; BYPASS=0 -> both show the old value (0) until after the edge.
REQ-036 Assert reset in the same cycle as a write of 32'h0000_0011 to r3 -> r3 reads 0 afterward; a write of 32'h0000_0022 to r3 on the next cycle with reset=0 -> r3 reads 32'h0000_0022.
REQ-037 reg_write=0 with num_write=9 and alu=32'h5555_5555 over 3 cycles -> r9 is unchanged (0).
